// File: rtl/multicycle_control_pkg.sv
// Shared opcode, immediate-format, instruction-class and state definitions for the
// multi-cycle control unit.
package multicycle_control_pkg;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpOpImm  = 7'b0010011;
    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [6:0] OpSystem = 7'b1110011;

    localparam logic [2:0] ImmNone  = 3'b000;
    localparam logic [2:0] ImmU     = 3'b001;
    localparam logic [2:0] ImmJ     = 3'b010;
    localparam logic [2:0] ImmI     = 3'b011;
    localparam logic [2:0] ImmB     = 3'b100;
    localparam logic [2:0] ImmS     = 3'b101;
    localparam logic [2:0] ImmShamt = 3'b110;

    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;

    localparam logic [1:0] WbAlu    = 2'b00;
    localparam logic [1:0] WbMem    = 2'b01;
    localparam logic [1:0] WbPc4    = 2'b10;

    localparam logic [1:0] PcPlus4  = 2'b00;
    localparam logic [1:0] PcImm    = 2'b01;
    localparam logic [1:0] PcAlu    = 2'b10;

    typedef enum logic [2:0] {
        StIf, StId, StEx, StMem, StWb, StStop
    } state_e;

    typedef enum logic [3:0] {
        ClsOp, ClsOpImm, ClsLui, ClsAuipc, ClsJal, ClsJalr,
        ClsBranch, ClsLoad, ClsStore, ClsSystem, ClsIllegal
    } inst_class_e;

endpackage

// File: rtl/multicycle_control_imm_format_decode.sv
// Opcode decoder: classifies the instruction and selects the immediate format.
module imm_format_decode
    import multicycle_control_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    output logic [2:0]  concat_control,
    output inst_class_e inst_class
);

    always_comb begin
        concat_control = ImmNone;
        inst_class     = ClsIllegal;
        case (opcode)
            OpLui:    begin concat_control = ImmU; inst_class = ClsLui;    end
            OpAuipc:  begin concat_control = ImmU; inst_class = ClsAuipc;  end
            OpJal:    begin concat_control = ImmJ; inst_class = ClsJal;    end
            OpJalr:   begin concat_control = ImmI; inst_class = ClsJalr;   end
            OpLoad:   begin concat_control = ImmI; inst_class = ClsLoad;   end
            OpBranch: begin concat_control = ImmB; inst_class = ClsBranch; end
            OpStore:  begin concat_control = ImmS; inst_class = ClsStore;  end
            OpOp:     inst_class = ClsOp;
            OpSystem: inst_class = ClsSystem;
            OpOpImm: begin
                inst_class = ClsOpImm;
                // shifts carry a 5-bit shamt rather than a full I immediate
                concat_control = (funct3 == 3'b001 || funct3 == 3'b101) ? ImmShamt : ImmI;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM (IF/ID/EX/MEM/WB/STOP) with retired-instruction counter.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [31:0] Instr,
    input  logic        Bcond,
    input  logic        I_MEM_READY,
    input  logic        D_MEM_READY,
    output logic        I_MEM_RE,
    output logic        IR_write,
    output logic [2:0]  Concat_control,
    output logic        ALU_srcA,
    output logic [1:0]  ALU_srcB,
    output logic        D_MEM_RE,
    output logic        D_MEM_WE,
    output logic        RF_WE,
    output logic [1:0]  WB_sel,
    output logic        PC_write,
    output logic [1:0]  PC_src,
    output logic        HALT,
    output logic        Illegal,
    output logic [31:0] NUM_INST
);

    state_e      state_q, state_d;
    logic [31:0] num_inst_q;
    logic        run_q;
    logic        retire;
    inst_class_e cls;

    logic unused_instr;
    assign unused_instr = ^{Instr[31:15], Instr[11:7]};

    imm_format_decode u_decode (
        .opcode         (Instr[6:0]),
        .funct3         (Instr[14:12]),
        .concat_control (Concat_control),
        .inst_class     (cls)
    );

    always_comb begin
        ALU_srcA = 1'b0;
        ALU_srcB = SrcBImm;
        case (cls)
            ClsAuipc, ClsJal:  ALU_srcA = 1'b1;
            ClsOp, ClsBranch:  ALU_srcB = SrcBRs2;
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        I_MEM_RE = 1'b0;
        IR_write = 1'b0;
        D_MEM_RE = 1'b0;
        D_MEM_WE = 1'b0;
        RF_WE    = 1'b0;
        PC_write = 1'b0;
        Illegal  = 1'b0;
        WB_sel   = WbAlu;
        PC_src   = PcPlus4;
        retire   = 1'b0;
        case (state_q)
            StIf: begin
                // run_q holds off the first fetch until the first edge after reset
                if (run_q) begin
                    I_MEM_RE = 1'b1;
                    if (I_MEM_READY) begin
                        IR_write = 1'b1;
                        state_d  = StId;
                    end
                end
            end
            StId: begin
                case (cls)
                    ClsSystem: state_d = StStop;
                    ClsIllegal: begin
                        Illegal  = 1'b1;
                        PC_write = 1'b1;
                        state_d  = StIf;
                    end
                    default: state_d = StEx;
                endcase
            end
            StEx: begin
                case (cls)
                    ClsBranch: begin
                        PC_write = 1'b1;
                        PC_src   = Bcond ? PcImm : PcPlus4;
                        retire   = 1'b1;
                        state_d  = StIf;
                    end
                    ClsLoad, ClsStore: state_d = StMem;
                    default:           state_d = StWb;
                endcase
            end
            StMem: begin
                if (cls == ClsLoad) D_MEM_RE = 1'b1;
                else                D_MEM_WE = 1'b1;
                if (D_MEM_READY) begin
                    if (cls == ClsLoad) begin
                        state_d = StWb;
                    end else begin
                        PC_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = StIf;
                    end
                end
            end
            StWb: begin
                RF_WE    = 1'b1;
                PC_write = 1'b1;
                retire   = 1'b1;
                state_d  = StIf;
                case (cls)
                    ClsJal:  begin WB_sel = WbPc4; PC_src = PcImm; end
                    ClsJalr: begin WB_sel = WbPc4; PC_src = PcAlu; end
                    ClsLoad: WB_sel = WbMem;
                    default: ;
                endcase
            end
            StStop: state_d = StStop;
            default: state_d = StIf;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= StIf;
            num_inst_q <= 32'd0;
            run_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            if (retire) num_inst_q <= num_inst_q + 32'd1;
        end
    end

    assign HALT     = (state_q == StStop);
    assign NUM_INST = num_inst_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed table-driven bench for multicycle_control plus wait-state, reset and halt sequences.
module tb_multicycle_control;

    logic        CLK, RSTn;
    logic [31:0] Instr;
    logic        Bcond, I_MEM_READY, D_MEM_READY;
    logic        I_MEM_RE, IR_write, ALU_srcA, D_MEM_RE, D_MEM_WE, RF_WE, PC_write;
    logic        HALT, Illegal;
    logic [2:0]  Concat_control;
    logic [1:0]  ALU_srcB, WB_sel, PC_src;
    logic [31:0] NUM_INST;

    int errors = 0;
    int checks = 0;

    multicycle_control dut (
        .CLK            (CLK),
        .RSTn           (RSTn),
        .Instr          (Instr),
        .Bcond          (Bcond),
        .I_MEM_READY    (I_MEM_READY),
        .D_MEM_READY    (D_MEM_READY),
        .I_MEM_RE       (I_MEM_RE),
        .IR_write       (IR_write),
        .Concat_control (Concat_control),
        .ALU_srcA       (ALU_srcA),
        .ALU_srcB       (ALU_srcB),
        .D_MEM_RE       (D_MEM_RE),
        .D_MEM_WE       (D_MEM_WE),
        .RF_WE          (RF_WE),
        .WB_sel         (WB_sel),
        .PC_write       (PC_write),
        .PC_src         (PC_src),
        .HALT           (HALT),
        .Illegal        (Illegal),
        .NUM_INST       (NUM_INST)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        logic        bcond;
        logic [2:0]  concat;
        logic        srca;
        logic [1:0]  srcb;
        int          lat;
        int          rf;
        logic [1:0]  wb;
        logic [1:0]  pcsrc;
        int          dre;
        int          dwe;
        int          ill;
        int          ret;
    } vec_t;

    typedef struct {
        int         cyc, rf, pcw, dre, dwe, ill, irw;
        logic [1:0] wb, pcsrc;
        logic [2:0] concat;
        logic       srca;
        logic [1:0] srcb;
        logic       done;
    } res_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one instruction from IF until the next IF; iw/dw are memory wait cycles.
    task automatic run_instr(input logic [31:0] instr, input logic bcond, input int iw_in,
                             input int dw_in, output res_t r);
        int  iw = iw_in;
        int  dw = dw_in;
        logic left = 1'b0;
        r = '{cyc: 0, rf: 0, pcw: 0, dre: 0, dwe: 0, ill: 0, irw: 0, wb: 2'b00,
              pcsrc: 2'b00, concat: 3'b000, srca: 1'b0, srcb: 2'b00, done: 1'b0};
        Instr = instr;
        Bcond = bcond;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            I_MEM_READY = (iw == 0);
            D_MEM_READY = (dw == 0);
            #1;
            if (I_MEM_RE && left) begin
                I_MEM_READY = 1'b0;
                r.done = 1'b1;
                break;
            end
            if (k == 0) begin
                r.concat = Concat_control;
                r.srca   = ALU_srcA;
                r.srcb   = ALU_srcB;
            end
            if (!I_MEM_RE) left = 1'b1;
            r.cyc++;
            if (IR_write) r.irw++;
            if (D_MEM_RE) r.dre++;
            if (D_MEM_WE) r.dwe++;
            if (Illegal)  r.ill++;
            if (RF_WE) begin r.rf++; r.wb = WB_sel; end
            if (PC_write) begin r.pcw++; r.pcsrc = PC_src; end
            if (I_MEM_RE && iw > 0) iw--;
            if ((D_MEM_RE || D_MEM_WE) && dw > 0) dw--;
        end
        I_MEM_READY = 1'b0;
    endtask

    vec_t        vecs[13];
    res_t        r;
    logic [31:0] n0;
    logic        found;

    initial begin
        //            instr         bc    concat  sA    sB     lat rf wb     pcsrc  dre dwe ill ret
        vecs[0]  = '{32'h00500093, 1'b0, 3'b011, 1'b0, 2'b01, 4, 1, 2'b00, 2'b00, 0, 0, 0, 1}; // ADDI
        vecs[1]  = '{32'h00000463, 1'b1, 3'b100, 1'b0, 2'b00, 3, 0, 2'b00, 2'b01, 0, 0, 0, 1}; // BEQ t
        vecs[2]  = '{32'h00000463, 1'b0, 3'b100, 1'b0, 2'b00, 3, 0, 2'b00, 2'b00, 0, 0, 0, 1}; // BEQ nt
        vecs[3]  = '{32'h00002083, 1'b0, 3'b011, 1'b0, 2'b01, 5, 1, 2'b01, 2'b00, 1, 0, 0, 1}; // LW
        vecs[4]  = '{32'h00102023, 1'b0, 3'b101, 1'b0, 2'b01, 4, 0, 2'b00, 2'b00, 0, 1, 0, 1}; // SW
        vecs[5]  = '{32'h00311113, 1'b0, 3'b110, 1'b0, 2'b01, 4, 1, 2'b00, 2'b00, 0, 0, 0, 1}; // SLLI
        vecs[6]  = '{32'h4010D093, 1'b0, 3'b110, 1'b0, 2'b01, 4, 1, 2'b00, 2'b00, 0, 0, 0, 1}; // SRAI
        vecs[7]  = '{32'h000100E7, 1'b0, 3'b011, 1'b0, 2'b01, 4, 1, 2'b10, 2'b10, 0, 0, 0, 1}; // JALR
        vecs[8]  = '{32'h010000EF, 1'b0, 3'b010, 1'b1, 2'b01, 4, 1, 2'b10, 2'b01, 0, 0, 0, 1}; // JAL
        vecs[9]  = '{32'h123450B7, 1'b0, 3'b001, 1'b0, 2'b01, 4, 1, 2'b00, 2'b00, 0, 0, 0, 1}; // LUI
        vecs[10] = '{32'h00001097, 1'b0, 3'b001, 1'b1, 2'b01, 4, 1, 2'b00, 2'b00, 0, 0, 0, 1}; // AUIPC
        vecs[11] = '{32'h002081B3, 1'b0, 3'b000, 1'b0, 2'b00, 4, 1, 2'b00, 2'b00, 0, 0, 0, 1}; // ADD
        vecs[12] = '{32'h0000007F, 1'b0, 3'b000, 1'b0, 2'b01, 2, 0, 2'b00, 2'b00, 0, 0, 1, 0}; // bad

        RSTn = 1'b0; Instr = 32'h0; Bcond = 1'b0; I_MEM_READY = 1'b0; D_MEM_READY = 1'b0;
        #1;
        check("rst I_MEM_RE", I_MEM_RE, 0);
        check("rst HALT", HALT, 0);
        check("rst Illegal", Illegal, 0);
        check("rst NUM_INST", NUM_INST, 0);
        check("rst strobes", {IR_write, D_MEM_RE, D_MEM_WE, RF_WE, PC_write}, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
        #1;
        check("pre-edge I_MEM_RE", I_MEM_RE, 0);
        @(posedge CLK);
        #1;
        check("first fetch I_MEM_RE", I_MEM_RE, 1);

        for (int i = 0; i < 13; i++) begin
            n0 = NUM_INST;
            run_instr(vecs[i].instr, vecs[i].bcond, 0, 0, r);
            check($sformatf("v%0d done", i), r.done, 1);
            check($sformatf("v%0d concat", i), r.concat, vecs[i].concat);
            check($sformatf("v%0d srcA", i), r.srca, vecs[i].srca);
            check($sformatf("v%0d srcB", i), r.srcb, vecs[i].srcb);
            check($sformatf("v%0d latency", i), r.cyc, vecs[i].lat);
            check($sformatf("v%0d IR_write", i), r.irw, 1);
            check($sformatf("v%0d RF_WE", i), r.rf, vecs[i].rf);
            if (vecs[i].rf > 0) check($sformatf("v%0d WB_sel", i), r.wb, vecs[i].wb);
            check($sformatf("v%0d PC_write", i), r.pcw, 1);
            check($sformatf("v%0d PC_src", i), r.pcsrc, vecs[i].pcsrc);
            check($sformatf("v%0d D_MEM_RE", i), r.dre, vecs[i].dre);
            check($sformatf("v%0d D_MEM_WE", i), r.dwe, vecs[i].dwe);
            check($sformatf("v%0d Illegal", i), r.ill, vecs[i].ill);
            check($sformatf("v%0d retire", i), NUM_INST - n0, vecs[i].ret);
        end

        // LW with two data-memory wait cycles
        run_instr(32'h00002083, 1'b0, 0, 2, r);
        check("lw-wait done", r.done, 1);
        check("lw-wait latency", r.cyc, 7);
        check("lw-wait D_MEM_RE", r.dre, 3);
        check("lw-wait WB_sel", r.wb, 2'b01);

        // ADDI with two instruction-memory wait cycles
        run_instr(32'h00500093, 1'b0, 2, 0, r);
        check("addi-iwait latency", r.cyc, 6);
        check("addi-iwait IR_write", r.irw, 1);

        // Reset asserted asynchronously while a load waits in MEM
        Instr = 32'h00002083;
        D_MEM_READY = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            I_MEM_READY = 1'b1;
            #1;
            if (D_MEM_RE) begin found = 1'b1; break; end
        end
        check("mem reached", found, 1);
        check("pre-rst NUM_INST nonzero", (NUM_INST != 0), 1);
        #1 RSTn = 1'b0;
        #1;
        check("midmem NUM_INST", NUM_INST, 0);
        check("midmem D_MEM_RE", D_MEM_RE, 0);
        check("midmem strobes", {I_MEM_RE, IR_write, D_MEM_WE, RF_WE, PC_write}, 0);
        check("midmem HALT", HALT, 0);
        I_MEM_READY = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        @(posedge CLK);
        #1;
        check("post-rst I_MEM_RE", I_MEM_RE, 1);
        run_instr(32'h00500093, 1'b0, 0, 0, r);
        check("post-rst latency", r.cyc, 4);
        check("post-rst NUM_INST", NUM_INST, 1);

        // ECALL halts permanently
        Instr = 32'h00000073;
        @(negedge CLK);
        I_MEM_READY = 1'b1;
        @(negedge CLK);
        #1;
        check("ecall ID Illegal", Illegal, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            #1;
            check($sformatf("stop%0d HALT", k), HALT, 1);
            check($sformatf("stop%0d strobes", k),
                  {I_MEM_RE, IR_write, D_MEM_RE, D_MEM_WE, RF_WE, PC_write}, 0);
            check($sformatf("stop%0d NUM_INST", k), NUM_INST, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have these ports: CLK  input  1  sole clock, rising edge.
REQ-002 SHALL have RSTn  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have Instr  input  32  current instruction, held stable by the instruction register.
REQ-004 SHALL have Bcond  input  1  branch-taken result from the ALU comparator, valid in EX.
REQ-005 SHALL have I_MEM_READY  input  1  instruction memory has data this cycle.
REQ-006 SHALL have D_MEM_READY  input  1  data memory access completes this cycle.
REQ-007 SHALL have I_MEM_RE  output  1  instruction fetch request.
REQ-008 SHALL have IR_write  output  1  latch Instr into the instruction register.
REQ-009 SHALL have Concat_control  output  3  immediate format select for the downstream immediate generator.
REQ-010 SHALL have ALU_srcA  output  1  0=rs1, 1=PC.
REQ-011 SHALL have ALU_srcB  output  2  00=rs2, 01=immediate, 10=constant 4.
REQ-012 SHALL have D_MEM_RE / D_MEM_WE  output  1 each  data read / write strobes.
REQ-013 SHALL have RF_WE  output  1  register-file write enable.
REQ-014 SHALL have WB_sel  output  2  00=ALU, 01=memory, 10=PC+4.
REQ-015 SHALL have PC_write  output  1  PC update strobe.
REQ-016 SHALL have PC_src  output  2  00=PC+4, 01=PC+imm, 10=ALU result with bit0 cleared.
REQ-017 SHALL have HALT, Illegal  output  1 each; NUM_INST  output  32  retired-instruction count.

Function
REQ-018 SHALL implement FSM states IF, ID, EX, MEM, WB, STOP.
REQ-019 IF: I_MEM_RE=1 and wait while I_MEM_READY=0; when I_MEM_READY=1, IR_write=1 and next state is ID.
REQ-020 ID: decode the opcode; 1110011 -> STOP; unknown opcode -> Illegal=1 for one cycle, PC_write=1, PC_src=00, next state IF; otherwise next state EX.
REQ-021 Concat_control SHALL be combinational from Instr: U-type (0110111, 0010111)=001; JAL=010; JALR, load, OP-IMM=011; OP-IMM with funct3 001/101=110; branch=100; store=101; otherwise 000.
REQ-022 EX: branch -> PC_write=1, PC_src=01 if Bcond else 00, retire, go to IF; load/store -> MEM; all other instructions -> WB.
REQ-023 MEM: load asserts D_MEM_RE and store asserts D_MEM_WE until D_MEM_READY=1; then a load goes to WB, and a store sets PC_write=1 and PC_src=00, retires, and goes to IF.
REQ-024 WB: RF_WE=1 and PC_write=1; WB_sel and PC_src are set as follows:
- JAL: WB_sel=10, PC_src=01.
- JALR: WB_sel=10, PC_src=10.
- load: WB_sel=01, PC_src=00.
- all others: WB_sel=00, PC_src=00.
Retire and go to IF.
REQ-025 With zero-wait memories, latency SHALL be: branch 3 cycles, R/I/U/J-type 4, store 4, load 5; each wait cycle adds 1.
REQ-026 Retire SHALL increment NUM_INST by 1, wrapping from FFFFFFFF to 0.
REQ-027 Strobes (I_MEM_RE, IR_write, D_MEM_*, RF_WE, PC_write) SHALL be 0 in every state/condition not listed above.
REQ-028 STOP SHALL be absorbing: HALT=1, all strobes 0, NUM_INST frozen until reset.
REQ-029 ALU_srcA/ALU_srcB SHALL be:
- AUIPC and JAL: PC/immediate.
- R-type and branch: rs1/rs2.
- All others: rs1/immediate.

Reset
REQ-030 RSTn low SHALL immediately force state IF, NUM_INST=0, HALT=0, Illegal=0 and all strobes 0, including mid-MEM or during waits.
REQ-031 The first fetch SHALL begin on the first rising CLK edge after RSTn deasserts.

Structure
REQ-032 The shared package SHALL hold the opcode constants, the Concat_control codes, and the state encodings.
REQ-033 The opcode-to-format decoder SHALL be one sub-module, imm_format_decode.

Verification
REQ-034 ADDI x1,x0,5 (00500093), zero-wait -> IF,ID,EX,WB over 4 cycles; Concat_control=011; RF_WE only in WB; NUM_INST 0->1.
REQ-035 BEQ with Bcond=1 -> 3 cycles, PC_src=01 in EX, RF_WE never 1; with Bcond=0 -> PC_src=00.
REQ-036 LW with D_MEM_READY low for 2 cycles -> D_MEM_RE held for 3 cycles, total latency 7, WB_sel=01.
REQ-037 SLLI x2,x2,3 -> Concat_control=110; JALR -> WB_sel=10, PC_src=10.
REQ-038 Opcode 1111111 -> Illegal pulses in ID, NUM_INST unchanged; ECALL -> HALT=1 held for 10 cycles; RSTn low in MEM -> state IF, NUM_INST=0.
